alu_mc: RTL
===========

Name: alu_mc

Overview:
Parametrised multi-cycle ALU, successor to the 16-bit combinational datapath ALU.
- Adds registered status flags (Z, N, V), shift operations and an iterative multiply.
- Uses a start/done handshake so the controller FSM can issue an op and wait on done.
- Sits in the datapath between the A/B operand registers and the C writeback/status registers.

Parameters:
- W, 16, datapath width in bits (W >= 4, power of two)
- SW, $clog2(W), shift-amount width (derived, not overridable)

Ports:
- clk, input, 1, rising-edge clock
- reset, input, 1, synchronous active-high reset
- start, input, 1, request a new operation; honoured only while ready=1
- ALUop, input, 3, operation select, sampled with start
- Ain, input, W, operand A, sampled with start
- Bin, input, W, operand B / shift amount (Bin[SW-1:0]), sampled with start
- ready, output, 1, 1 when idle and able to accept start
- done, output, 1, one-cycle pulse; out/status valid and updated this cycle
- out, output, W, result register
- status, output, 3, {V,N,Z} flag register

Behaviour:
Clock and reset:
- One clock, clk. Reset is synchronous and active-high on port reset.
- reset=1 at a clk edge forces: state=IDLE, ready=1, done=0, out=0, status=3'b000, internal counters=0.
- Reset overrides a simultaneous start.
- Reset during BUSY aborts the op: no done pulse, out/status cleared.

Ops:
- 000 ADD: A+B.
- 001 SUB: A-B.
- 010 AND: A&B.
- 011 NOTB: ~B.
- 100 SHL: A << amt.
- 101 LSR: A >> amt, logical.
- 110 ASR: A >>> amt, arithmetic.
- 111 MUL: low W bits of unsigned A*B.
- amt = Bin[SW-1:0].

FSM: IDLE, BUSY.
- IDLE: ready=1. start=1 latches ALUop/Ain/Bin, loads the counter and moves to BUSY.
- BUSY: ready=0. start is ignored; operands are not re-sampled.
- Counter reaching its terminal value writes out/status, pulses done for exactly one cycle and returns to IDLE. ready=1 in that same cycle.
- Back-to-back ops: start may be asserted in the done cycle and is accepted.

Latency (accept edge to the edge at which done rises):
- ADD/SUB/AND/NOTB: 1.
- Shifts: amt+1. Shift by one bit per BUSY cycle; amt=0 gives 1 and returns A unchanged.
- MUL: W. Shift-add, one multiplier bit per cycle, accumulator W bits, overflow discarded.

Flags (computed on the final result, registered with done):
- Z = (out == 0).
- N = out[W-1].
- V = signed two's-complement overflow for ADD/SUB; V = 0 for all other ops.
- status holds its value between done pulses.
- out holds the last result between ops. It is not updated with intermediate values; partial results live in internal registers only.

Arithmetic:
- All arithmetic is modulo 2^W.
- SUB is A + ~B + 1.
- V(ADD) = (A[W-1]==B[W-1]) && (R[W-1]!=A[W-1]).
- V(SUB) = (A[W-1]!=B[W-1]) && (R[W-1]!=A[W-1]).

Decomposition:
- Package alu_pkg:
  - op encodings: OP_ADD..OP_MUL, 3-bit localparams
  - FSM state encoding: S_IDLE, S_BUSY
  - flag bit indices: FLAG_Z=0, FLAG_N=1, FLAG_V=2
- Sub-module alu_core: combinational, parametrised by W.
  - Covers ADD/SUB/AND/NOTB.
  - Produces result plus V flag for the single-cycle path.
- The top level owns the FSM, shift/multiply iteration registers and the output/flag registers.

Test Plan:
- W=16, ADD Ain=3, Bin=2, start for 1 cycle -> done 1 cycle after accept, out=16'd5, status=3'b000; then SUB 1-2 -> out=16'hFFFF, status=3'b010 (N=1).
- ADD 16'h7FFF+16'h0001 -> out=16'h8000, status=3'b110 (V=1, N=1); SUB 16'h8000-16'h0001 -> out=16'h7FFF, V=1, N=0.
- NOTB Bin=16'hFFFF -> out=0, status=3'b001; AND 16'hF566 & 16'h6FF6 -> out=16'h6566, Z=0.
- SHL Ain=16'h0001, Bin=4 -> ready low 5 cycles, done 5 cycles after accept, out=16'h0010. Assert start with ADD mid-BUSY -> ignored, out stays 16'h0010. ASR 16'h8000 by 15 -> 16'hFFFF, N=1.
- MUL 300*200 -> done 16 cycles after accept, out=16'hEA60, Z=0, V=0; MUL 16'h0100*16'h0100 -> out=0, Z=1 (overflow wraps).
- Start MUL, assert reset on cycle 5 -> no done pulse ever for that op, next cycle ready=1, out=0, status=0. reset and start in the same cycle -> start not accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: op codes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOTB = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_LSR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

  // True for the three ops that iterate one bit position per BUSY cycle.
  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_LSR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle datapath: ADD, SUB, AND, NOTB plus signed overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         ovf
);

  logic [W-1:0] sum;
  logic [W-1:0] diff;

  assign sum  = a + b;
  assign diff = a + ~b + W'(1);

  // Select the single-cycle result; overflow is only meaningful for ADD and SUB.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum;
        ovf    = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_AND:  result = a & b;
      OP_NOTB: result = ~b;
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with start/done handshake, iterative shifts, shift-add multiply
// and registered {V,N,Z} status.
module alu_mc
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           ALUop,
  input  logic [W-1:0]         Ain,
  input  logic [W-1:0]         Bin,
  output logic                 ready,
  output logic                 done,
  output logic [W-1:0]         out,
  output logic [2:0]           status
);

  localparam int SW = $clog2(W);

  state_t         state;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   acc_q;
  logic [SW-1:0]  cnt_q;

  logic [W-1:0]   core_result;
  logic           core_v;
  logic [W-1:0]   shift_next;
  logic [W-1:0]   mul_next;
  logic [W-1:0]   fin_result;
  logic           fin_v;
  logic           finish;
  logic [2:0]     fin_flags;

  alu_core #(.W(W)) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (core_result),
    .ovf    (core_v)
  );

  // One-bit step of the shift register for the latched shift op.
  always_comb begin
    shift_next = acc_q;
    case (op_q)
      OP_SHL:  shift_next = {acc_q[W-2:0], 1'b0};
      OP_LSR:  shift_next = {1'b0, acc_q[W-1:1]};
      OP_ASR:  shift_next = {acc_q[W-1], acc_q[W-1:1]};
      default: shift_next = acc_q;
    endcase
  end

  // Shift-add step: a_q is the multiplicand moving left, b_q the multiplier moving right.
  assign mul_next = acc_q + (b_q[0] ? a_q : '0);

  // Decide whether this BUSY cycle completes the op and what gets written back.
  always_comb begin
    fin_result = core_result;
    fin_v      = core_v;
    finish     = 1'b1;
    if (is_shift(op_q)) begin
      fin_result = acc_q;
      fin_v      = 1'b0;
      finish     = (cnt_q == '0);
    end else if (op_q == OP_MUL) begin
      fin_result = mul_next;
      fin_v      = 1'b0;
      finish     = (cnt_q == '0);
    end
    fin_flags         = '0;
    fin_flags[FLAG_Z] = (fin_result == '0);
    fin_flags[FLAG_N] = fin_result[W-1];
    fin_flags[FLAG_V] = fin_v;
  end

  // Control FSM plus iteration registers and the result/status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      out    <= '0;
      status <= '0;
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= ALUop;
            a_q   <= Ain;
            b_q   <= Bin;
            state <= S_BUSY;
            ready <= 1'b0;
            if (ALUop == OP_MUL) begin
              acc_q <= '0;
              cnt_q <= SW'(W - 1);
            end else begin
              acc_q <= Ain;
              cnt_q <= Bin[SW-1:0];
            end
          end
        end
        S_BUSY: begin
          if (finish) begin
            out    <= fin_result;
            status <= fin_flags;
            done   <= 1'b1;
            ready  <= 1'b1;
            state  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (op_q == OP_MUL) begin
              acc_q <= mul_next;
              a_q   <= {a_q[W-2:0], 1'b0};
              b_q   <= {1'b0, b_q[W-1:1]};
            end else begin
              acc_q <= shift_next;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
